// File: rtl/alu_seq_pkg.sv
// Shared types and op-class tables for the 65C02 ALU sequencer and instruction decode.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_ORA = 4'h1,
        OP_EOR = 4'h2,
        OP_ADC = 4'h3,
        OP_SBC = 4'h4,
        OP_ASL = 4'h5,
        OP_LSR = 4'h6,
        OP_ROL = 4'h7,
        OP_ROR = 4'h8,
        OP_BIT = 4'h9,
        OP_CMP = 4'hA,
        OP_TSB = 4'hB,
        OP_TRB = 4'hC,
        OP_D2B = 4'hD,
        OP_B2D = 4'hE
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        D2B,
        EXEC,
        WAIT_PSR,
        ACK,
        B2D,
        ABORT
    } seq_state_e;

    // One bit per op code; bit n set means op n belongs to the class.
    localparam logic [15:0] ACC_OPS     = 16'h001F;
    localparam logic [15:0] RMW_OPS     = 16'h19E0;
    localparam logic [15:0] FLAG_OPS    = 16'h0600;
    localparam logic [15:0] ARITH_OPS   = 16'h0018;
    localparam logic [15:0] ILLEGAL_OPS = 16'hE000;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/ALU-control bundle between instruction decode, the sequencer and the ALU.
interface alu_sequencer_if;
    logic       start;
    logic [3:0] op;
    logic       d_decimal;
    logic       psr_update_request;
    logic       busy;
    logic       done;
    logic       err;
    logic       instruction_decode_in;
    logic       acc_to_alu_xfer;
    logic       compute_step;
    logic [3:0] operation_select;
    logic       ack_update_request;
    logic       acc_we;
    logic       mem_we;

    modport master (
        output start, op, d_decimal, psr_update_request,
        input  busy, done, err, instruction_decode_in, acc_to_alu_xfer,
               compute_step, operation_select, ack_update_request, acc_we, mem_we
    );

    modport slave (
        input  start, op, d_decimal, psr_update_request,
        output busy, done, err, instruction_decode_in, acc_to_alu_xfer,
               compute_step, operation_select, ack_update_request, acc_we, mem_we
    );
endinterface

// File: rtl/alu_sequencer_op_class.sv
// Combinational op-code classifier, shared by the sequencer and instruction decode.
module alu_op_class
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_acc,
    output logic       is_rmw,
    output logic       is_flag,
    output logic       is_illegal,
    output logic       is_arith
);

    logic [15:0] op_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_decode
            assign op_onehot[gi] = (op == 4'(gi));
        end
    endgenerate

    assign is_acc     = |(op_onehot & ACC_OPS);
    assign is_rmw     = |(op_onehot & RMW_OPS);
    assign is_flag    = |(op_onehot & FLAG_OPS);
    assign is_illegal = |(op_onehot & ILLEGAL_OPS);
    assign is_arith   = |(op_onehot & ARITH_OPS);

endmodule

// File: rtl/alu_sequencer.sv
// Cycle-level ALU controller: load, optional BCD passes, compute, PSR handshake with
// bounded wait, and writeback strobes. Outputs decode only registered state.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned PSR_TIMEOUT = 15
) (
    input  logic            fclk,
    input  logic            resb,
    alu_sequencer_if.slave  bus
);

    localparam int unsigned    CNT_W    = (PSR_TIMEOUT < 1) ? 1 : $clog2(PSR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PSR_TIMEOUT);

    seq_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    alu_op_e          op_reg, op_next;
    logic             dec_reg, dec_next;
    logic             acc_reg, acc_next;
    logic             rmw_reg, rmw_next;
    logic             bad_op_reg, bad_op_next;

    logic cls_acc, cls_rmw, cls_flag, cls_illegal, cls_arith;

    alu_op_class u_op_class (
        .op         (bus.op),
        .is_acc     (cls_acc),
        .is_rmw     (cls_rmw),
        .is_flag    (cls_flag),
        .is_illegal (cls_illegal),
        .is_arith   (cls_arith)
    );

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_reg     <= OP_AND;
            dec_reg    <= 1'b0;
            acc_reg    <= 1'b0;
            rmw_reg    <= 1'b0;
            bad_op_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            dec_reg    <= dec_next;
            acc_reg    <= acc_next;
            rmw_reg    <= rmw_next;
            bad_op_reg <= bad_op_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        dec_next    = dec_reg;
        acc_next    = acc_reg;
        rmw_next    = rmw_reg;
        bad_op_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    // Anything the classifier does not place in a class is rejected.
                    if (cls_illegal || !(cls_acc || cls_rmw || cls_flag)) begin
                        bad_op_next = 1'b1;
                    end else begin
                        op_next    = alu_op_e'(bus.op);
                        dec_next   = bus.d_decimal & cls_arith;
                        acc_next   = cls_acc;
                        rmw_next   = cls_rmw;
                        state_next = LOAD;
                    end
                end
            end
            LOAD:     state_next = dec_reg ? D2B : EXEC;
            D2B:      state_next = EXEC;
            EXEC: begin
                cnt_next   = '0;
                state_next = WAIT_PSR;
            end
            WAIT_PSR: begin
                if (bus.psr_update_request) begin
                    state_next = ACK;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ABORT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ACK:      state_next = dec_reg ? B2D : IDLE;
            B2D:      state_next = IDLE;
            ABORT:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy                  = (state_reg != IDLE);
        bus.done                  = 1'b0;
        bus.err                   = bad_op_reg;
        bus.instruction_decode_in = 1'b0;
        bus.acc_to_alu_xfer       = 1'b0;
        bus.compute_step          = 1'b0;
        bus.operation_select      = op_reg;
        bus.ack_update_request    = 1'b0;
        bus.acc_we                = 1'b0;
        bus.mem_we                = 1'b0;
        case (state_reg)
            LOAD: begin
                bus.instruction_decode_in = 1'b1;
                bus.acc_to_alu_xfer       = 1'b1;
            end
            D2B: begin
                bus.compute_step     = 1'b1;
                bus.operation_select = OP_D2B;
            end
            EXEC: bus.compute_step = 1'b1;
            ACK: begin
                bus.ack_update_request = 1'b1;
                // Decimal ops defer completion and writeback to the B2D pass.
                if (!dec_reg) begin
                    bus.done   = 1'b1;
                    bus.acc_we = acc_reg;
                    bus.mem_we = rmw_reg;
                end
            end
            B2D: begin
                bus.compute_step     = 1'b1;
                bus.operation_select = OP_B2D;
                bus.acc_we           = 1'b1;
                bus.done             = 1'b1;
            end
            ABORT: begin
                bus.err  = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Cycle-by-cycle check of alu_sequencer against a per-transaction expected-output trace.
module tb_alu_sequencer;

    localparam int TO = 15;

    logic fclk = 1'b0;
    logic resb;

    alu_sequencer_if bus ();

    alu_sequencer #(.PSR_TIMEOUT(TO)) dut (
        .fclk (fclk),
        .resb (resb),
        .bus  (bus)
    );

    always #5 fclk = ~fclk;

    int          tests  = 0;
    int          fails  = 0;
    int          txn_id = 0;
    logic [12:0] exp_q[$];
    logic [3:0]  last_op = 4'h0;

    // {busy, done, err, idi, a2a, compute, sel[3:0], ack, acc_we, mem_we}
    function automatic logic [12:0] vec(input bit busy, input bit done, input bit err,
                                        input bit idi, input bit a2a, input bit cs,
                                        input logic [3:0] sel, input bit ack,
                                        input bit acc, input bit mem);
        return {busy, done, err, idi, a2a, cs, sel, ack, acc, mem};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.busy, bus.done, bus.err, bus.instruction_decode_in, bus.acc_to_alu_xfer,
                bus.compute_step, bus.operation_select, bus.ack_update_request,
                bus.acc_we, bus.mem_we};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected outputs for cycles 1.. of one request, plus the trailing idle cycle.
    // req_at: first cycle the ALU request is high (held afterwards); -1 = never.
    function automatic void build(input int op, input bit d, input int req_at);
        bit         illegal = (op > 12);
        bit         acc     = (op <= 4);
        bit         rmw     = (op >= 5 && op <= 8) || op == 11 || op == 12;
        bit         dec     = d && (op == 3 || op == 4);
        logic [3:0] sel     = 4'(op);
        int         w, n;
        bit         abort;
        if (illegal) begin
            exp_q.push_back(vec(0, 0, 1, 0, 0, 0, last_op, 0, 0, 0));
            exp_q.push_back(vec(0, 0, 0, 0, 0, 0, last_op, 0, 0, 0));
            return;
        end
        exp_q.push_back(vec(1, 0, 0, 1, 1, 0, sel, 0, 0, 0));
        if (dec) exp_q.push_back(vec(1, 0, 0, 0, 0, 1, 4'hD, 0, 0, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 1, sel, 0, 0, 0));
        w = dec ? 4 : 3;
        if (req_at >= 0) n = ((req_at > w) ? req_at : w) - w + 1;
        else             n = TO + 2;
        abort = (n > TO + 1);
        if (abort) n = TO + 1;
        repeat (n) exp_q.push_back(vec(1, 0, 0, 0, 0, 0, sel, 0, 0, 0));
        if (abort) begin
            exp_q.push_back(vec(1, 1, 1, 0, 0, 0, sel, 0, 0, 0));
        end else if (dec) begin
            exp_q.push_back(vec(1, 0, 0, 0, 0, 0, sel, 1, 0, 0));
            exp_q.push_back(vec(1, 1, 0, 0, 0, 1, 4'hE, 0, 1, 0));
        end else begin
            exp_q.push_back(vec(1, 1, 0, 0, 0, 0, sel, 1, acc, rmw));
        end
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, sel, 0, 0, 0));
        last_op = sel;
    endfunction

    // Called #1 after a rising edge with the sequencer idle.
    task automatic run_txn(input int op, input bit d, input int req_at, input bit noise);
        exp_q.delete();
        build(op, d, req_at);
        txn_id++;
        $display("[TB] txn %0d op=%h d=%0d req_at=%0d noise=%0d", txn_id, op, d, req_at, noise);
        bus.start              = 1'b1;
        bus.op                 = 4'(op);
        bus.d_decimal          = d;
        bus.psr_update_request = (req_at == 0);
        @(posedge fclk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= exp_q.size(); k++) begin
            bus.psr_update_request = (req_at >= 0 && k >= req_at);
            check($sformatf("txn%0d_op%h_cyc%0d", txn_id, op, k), observed(), exp_q[k-1]);
            if (noise && k == 1) begin
                bus.start = 1'b1;
                bus.op    = 4'($urandom_range(0, 15));
            end
            if (noise && k == 2) bus.start = 1'b0;
            @(posedge fclk); #1;
        end
        bus.psr_update_request = 1'b0;
    endtask

    initial begin
        int  rop, rreq;
        bit  rd, rnoise;
        resb                   = 1'b0;
        bus.start              = 1'b0;
        bus.op                 = 4'h0;
        bus.d_decimal          = 1'b0;
        bus.psr_update_request = 1'b0;
        #12;
        check("reset_state", observed(), 13'h0);
        @(negedge fclk) resb = 1'b1;
        @(posedge fclk); #1;

        run_txn(4'h0, 1'b0, 3, 1'b0);       // AND, request rises with WAIT_PSR
        run_txn(4'h3, 1'b1, 0, 1'b0);       // decimal ADC
        run_txn(4'h7, 1'b1, 0, 1'b0);       // ROL ignores D
        run_txn(4'hA, 1'b0, -1, 1'b0);      // CMP timeout
        run_txn(4'hE, 1'b0, 0, 1'b0);       // illegal op
        run_txn(4'h4, 1'b1, 7, 1'b1);       // decimal SBC, late request, stray start
        run_txn(4'h9, 1'b0, 3 + TO, 1'b0);  // request in last WAIT_PSR cycle
        run_txn(4'h2, 1'b0, 4 + TO, 1'b0);  // request one cycle too late
        run_txn(4'h3, 1'b1, -1, 1'b0);      // decimal timeout skips B2D

        // Asynchronous reset while waiting on the ALU.
        $display("[TB] txn reset during WAIT_PSR");
        bus.start     = 1'b1;
        bus.op        = 4'h1;
        bus.d_decimal = 1'b0;
        @(posedge fclk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge fclk); #1; end
        check("pre_reset_wait", observed(), vec(1, 0, 0, 0, 0, 0, 4'h1, 0, 0, 0));
        resb = 1'b0;
        #1;
        check("async_reset", observed(), 13'h0);
        @(negedge fclk) resb = 1'b1;
        @(posedge fclk); #1;
        check("post_reset_idle", observed(), 13'h0);
        last_op = 4'h0;
        run_txn(4'hB, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rop    = $urandom_range(0, 15);
            rd     = 1'($urandom_range(0, 1));
            rreq   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 22);
            rnoise = (rop <= 12) && ($urandom_range(0, 1) == 1);
            run_txn(rop, rd, rreq, rnoise);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
